// File: rtl/gen_lane_pkg.sv
// Shared constants and helpers for the gen_lane_pipe delay array.
package gen_lane_pkg;

  localparam int unsigned SIG_W        = 64;
  localparam int unsigned MISR_TAP_HI  = 63;
  localparam int unsigned MISR_TAP_MID = 2;
  localparam int unsigned MISR_TAP_LO  = 0;

  // Even lanes take depth_even stages, odd lanes depth_odd.
  function automatic int unsigned depth_of(input int unsigned lane,
                                           input int unsigned depth_even,
                                           input int unsigned depth_odd);
    return (lane % 2 == 0) ? depth_even : depth_odd;
  endfunction

endpackage

// File: rtl/gen_lane_stage.sv
// One lane: DEPTH-stage registered shift pipeline of WIDTH data bits plus a valid bit.
module gen_lane_stage
  import gen_lane_pkg::*;
#(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  output logic [WIDTH-1:0] tap_data
);

  logic [WIDTH-1:0] data_q [DEPTH];
  logic [DEPTH-1:0] valid_q;

  // Clear beats advance; data is captured even when in_valid is low.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      for (int unsigned k = 0; k < DEPTH; k++) begin
        data_q[k] <= '0;
      end
      valid_q <= '0;
    end else if (en) begin
      data_q[0]  <= in_data;
      valid_q[0] <= in_valid;
      for (int unsigned k = 1; k < DEPTH; k++) begin
        data_q[k]  <= data_q[k-1];
        valid_q[k] <= valid_q[k-1];
      end
    end
  end

  assign out_data  = data_q[DEPTH-1];
  assign out_valid = valid_q[DEPTH-1];
  assign tap_data  = data_q[0];

endmodule

// File: rtl/gen_lane_pipe.sv
// Multi-lane delay array with per-parity depth and first-stage taps.
// Optional 64-bit output MISR when GEN_LANE_SIG_EN is defined.
module gen_lane_pipe
  import gen_lane_pkg::*;
#(
  parameter int unsigned LANES      = 4,
  parameter int unsigned WIDTH      = 1,
  parameter int unsigned DEPTH_EVEN = 1,
  parameter int unsigned DEPTH_ODD  = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   flush,
  input  logic                   in_valid,
  input  logic [LANES*WIDTH-1:0] in_data,
  output logic [LANES*WIDTH-1:0] out_data,
  output logic [LANES-1:0]       out_valid,
  output logic [LANES*WIDTH-1:0] tap_data,
  output logic [SIG_W-1:0]       sig
);

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    if (i % 2 == 0) begin : g_even
      gen_lane_stage #(.WIDTH(WIDTH), .DEPTH(DEPTH_EVEN)) u_stage (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .flush    (flush),
        .in_valid (in_valid),
        .in_data  (in_data[i*WIDTH +: WIDTH]),
        .out_data (out_data[i*WIDTH +: WIDTH]),
        .out_valid(out_valid[i]),
        .tap_data (tap_data[i*WIDTH +: WIDTH])
      );
    end else begin : g_odd
      gen_lane_stage #(.WIDTH(WIDTH), .DEPTH(DEPTH_ODD)) u_stage (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .flush    (flush),
        .in_valid (in_valid),
        .in_data  (in_data[i*WIDTH +: WIDTH]),
        .out_data (out_data[i*WIDTH +: WIDTH]),
        .out_valid(out_valid[i]),
        .tap_data (tap_data[i*WIDTH +: WIDTH])
      );
    end
  end

`ifdef GEN_LANE_SIG_EN
  logic [SIG_W-1:0] sig_q;
  logic             misr_fb;

  assign misr_fb = sig_q[MISR_TAP_HI] ^ sig_q[MISR_TAP_MID] ^ sig_q[MISR_TAP_LO];

  // Compresses pre-edge out/tap words; flush leaves the signature intact.
  always_ff @(posedge clk) begin
    if (rst) begin
      sig_q <= '0;
    end else if (!flush && en) begin
      sig_q <= {sig_q[SIG_W-2:0], misr_fb} ^ SIG_W'({out_data, tap_data});
    end
  end

  assign sig = sig_q;
`else
  assign sig = '0;
`endif

endmodule
